// File: rtl/pkt_monitor_pkg.sv
// Shared stream types for the packet monitor: the avln_st beat and the framing FSM states.
package pkt_monitor_pkg;

    localparam int unsigned AVLN_DATA_BYTES = 8;
    localparam int unsigned AVLN_EMPTY_W    = $clog2(AVLN_DATA_BYTES);

    typedef struct packed {
        logic [AVLN_DATA_BYTES*8-1:0] data;
        logic                         sop;
        logic                         eop;
        logic [AVLN_EMPTY_W-1:0]      empty;
        logic                         valid;
    } avln_st;

    typedef enum logic [0:0] {
        PM_IDLE,
        PM_IN_PKT
    } pkt_mon_state_t;

endpackage

// File: rtl/pkt_monitor_sat_counter.sv
// Saturating accumulator: synchronous clear beats increment; never wraps past all-ones.
module sat_counter #(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic [AW-1:0] add_i,
    output logic [W-1:0]  cnt_o
);

    localparam int unsigned SW = ((W > AW) ? W : AW) + 1;
    localparam logic [SW-1:0] CntMax = SW'({W{1'b1}});

    logic [W-1:0]  cnt_q, cnt_d;
    logic [SW-1:0] sum;

    always_comb begin
        sum   = SW'(cnt_q) + SW'(add_i);
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = (sum > CntMax) ? {W{1'b1}} : sum[W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pkt_monitor.sv
// Pass-through packet monitor with framing FSM and saturating statistics.
// Build option PKT_MON_DROP_EN: suppress valid/sop/eop of stray beats on the output.
module pkt_monitor
    import pkt_monitor_pkg::*;
#(
    parameter int unsigned DATA_BYTES = AVLN_DATA_BYTES,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned LEN_W      = 16
) (
    input  logic             sys_clk_i,
    input  logic             reset_ni,
    input  avln_st           in_i,
    input  logic             clr_i,
    output avln_st           out_o,
    output logic             in_pkt_o,
    output logic [CNT_W-1:0] pkt_cnt_o,
    output logic [CNT_W-1:0] byte_cnt_o,
    output logic [CNT_W-1:0] sop_err_cnt_o,
    output logic [CNT_W-1:0] stray_cnt_o,
    output logic [LEN_W-1:0] last_len_o,
    output logic [LEN_W-1:0] max_len_o
);

    localparam logic [LEN_W-1:0] BeatLen = LEN_W'(DATA_BYTES);

    pkt_mon_state_t   state_q, state_d;
    logic [LEN_W-1:0] cur_len_q, cur_len_d;
    logic [LEN_W-1:0] last_len_q, last_len_d;
    logic [LEN_W-1:0] max_len_q, max_len_d;
    avln_st           out_q, out_d;

    logic [LEN_W:0]   fb;
    logic [LEN_W:0]   cur_plus_fb;
    logic [LEN_W:0]   cur_plus_beat;
    logic             done;
    logic [LEN_W-1:0] done_len;
    logic             stray;
    logic             sop_err;

    // Operands never exceed twice the max, so the carry bit alone flags overflow.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W:0] v);
        return v[LEN_W] ? {LEN_W{1'b1}} : v[LEN_W-1:0];
    endfunction

    assign fb            = (LEN_W+1)'(DATA_BYTES) - (LEN_W+1)'(in_i.empty);
    assign cur_plus_fb   = {1'b0, cur_len_q} + fb;
    assign cur_plus_beat = {1'b0, cur_len_q} + {1'b0, BeatLen};

    always_comb begin
        state_d   = state_q;
        cur_len_d = cur_len_q;
        done      = 1'b0;
        done_len  = '0;
        stray     = 1'b0;
        sop_err   = 1'b0;
        if (in_i.valid) begin
            unique case (state_q)
                PM_IDLE: begin
                    if (in_i.sop && in_i.eop) begin
                        done     = 1'b1;
                        done_len = sat_len(fb);
                    end else if (in_i.sop) begin
                        state_d   = PM_IN_PKT;
                        cur_len_d = BeatLen;
                    end else begin
                        stray = 1'b1;
                    end
                end
                PM_IN_PKT: begin
                    if (in_i.sop) begin
                        // Abort the open packet; this beat starts a fresh one.
                        sop_err = 1'b1;
                        if (in_i.eop) begin
                            done     = 1'b1;
                            done_len = sat_len(fb);
                            state_d  = PM_IDLE;
                        end else begin
                            cur_len_d = BeatLen;
                        end
                    end else if (in_i.eop) begin
                        done     = 1'b1;
                        done_len = sat_len(cur_plus_fb);
                        state_d  = PM_IDLE;
                    end else begin
                        cur_len_d = sat_len(cur_plus_beat);
                    end
                end
            endcase
        end
    end

    always_comb begin
        last_len_d = last_len_q;
        max_len_d  = max_len_q;
        if (clr_i) begin
            last_len_d = '0;
            max_len_d  = '0;
        end else if (done) begin
            last_len_d = done_len;
            if (done_len > max_len_q) begin
                max_len_d = done_len;
            end
        end
    end

    always_comb begin
        out_d = in_i;
`ifdef PKT_MON_DROP_EN
        if (stray) begin
            out_d.valid = 1'b0;
            out_d.sop   = 1'b0;
            out_d.eop   = 1'b0;
        end
`endif
    end

    always_ff @(posedge sys_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= PM_IDLE;
            cur_len_q  <= '0;
            last_len_q <= '0;
            max_len_q  <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_len_q  <= cur_len_d;
            last_len_q <= last_len_d;
            max_len_q  <= max_len_d;
            out_q      <= out_d;
        end
    end

    sat_counter #(.W(CNT_W), .AW(1)) u_pkt_cnt (
        .clk_i  (sys_clk_i),
        .rst_ni (reset_ni),
        .clr_i  (clr_i),
        .inc_i  (done),
        .add_i  (1'b1),
        .cnt_o  (pkt_cnt_o)
    );

    sat_counter #(.W(CNT_W), .AW(LEN_W)) u_byte_cnt (
        .clk_i  (sys_clk_i),
        .rst_ni (reset_ni),
        .clr_i  (clr_i),
        .inc_i  (done),
        .add_i  (done_len),
        .cnt_o  (byte_cnt_o)
    );

    sat_counter #(.W(CNT_W), .AW(1)) u_sop_err_cnt (
        .clk_i  (sys_clk_i),
        .rst_ni (reset_ni),
        .clr_i  (clr_i),
        .inc_i  (sop_err),
        .add_i  (1'b1),
        .cnt_o  (sop_err_cnt_o)
    );

    sat_counter #(.W(CNT_W), .AW(1)) u_stray_cnt (
        .clk_i  (sys_clk_i),
        .rst_ni (reset_ni),
        .clr_i  (clr_i),
        .inc_i  (stray),
        .add_i  (1'b1),
        .cnt_o  (stray_cnt_o)
    );

    assign out_o      = out_q;
    assign in_pkt_o   = (state_q == PM_IN_PKT);
    assign last_len_o = last_len_q;
    assign max_len_o  = max_len_q;

endmodule

// File: tb/tb_pkt_monitor.sv
// Randomized bench for pkt_monitor: a default-size and a narrow-counter instance share stimulus
// and are compared against a packet-level reference model using unbounded counts.
module tb_pkt_monitor;
    import pkt_monitor_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    avln_st in_s;
    logic   clr;

    always #5 clk = ~clk;

    avln_st      out_a, out_b;
    logic        inpkt_a, inpkt_b;
    logic [31:0] pkt_a, byte_a, err_a, stray_a;
    logic [15:0] last_a, max_a;
    logic [3:0]  pkt_b, byte_b, err_b, stray_b;
    logic [7:0]  last_b, max_b;

    pkt_monitor dut (
        .sys_clk_i     (clk),
        .reset_ni      (rst_n),
        .in_i          (in_s),
        .clr_i         (clr),
        .out_o         (out_a),
        .in_pkt_o      (inpkt_a),
        .pkt_cnt_o     (pkt_a),
        .byte_cnt_o    (byte_a),
        .sop_err_cnt_o (err_a),
        .stray_cnt_o   (stray_a),
        .last_len_o    (last_a),
        .max_len_o     (max_a)
    );

    pkt_monitor #(.CNT_W(4), .LEN_W(8)) dut_s (
        .sys_clk_i     (clk),
        .reset_ni      (rst_n),
        .in_i          (in_s),
        .clr_i         (clr),
        .out_o         (out_b),
        .in_pkt_o      (inpkt_b),
        .pkt_cnt_o     (pkt_b),
        .byte_cnt_o    (byte_b),
        .sop_err_cnt_o (err_b),
        .stray_cnt_o   (stray_b),
        .last_len_o    (last_b),
        .max_len_o     (max_b)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: true (unbounded) quantities since the last reset/clr.
    longint m_pkt, m_bytes, m_err, m_stray, m_last, m_max, m_cur;
    bit     m_inpkt;
    avln_st m_out;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic avln_st mk(input bit v, input bit s, input bit e, input int emp);
        avln_st b;
        b.data  = {$urandom, $urandom};
        b.valid = v;
        b.sop   = s;
        b.eop   = e;
        b.empty = AVLN_EMPTY_W'(emp);
        return b;
    endfunction

    task automatic model_reset();
        m_pkt = 0; m_bytes = 0; m_err = 0; m_stray = 0;
        m_last = 0; m_max = 0; m_cur = 0; m_inpkt = 0;
        m_out = '0;
    endtask

    task automatic complete(input longint len);
        m_pkt++;
        m_bytes += len;
        m_last = len;
        if (len > m_max) m_max = len;
    endtask

    task automatic model_step(input avln_st b, input logic c);
        longint fb;
        fb    = 8 - longint'(b.empty);
        m_out = b;
        if (b.valid) begin
            if (!m_inpkt) begin
                if (b.sop && b.eop) complete(fb);
                else if (b.sop) begin m_inpkt = 1; m_cur = 8; end
                else begin
                    m_stray++;
`ifdef PKT_MON_DROP_EN
                    m_out.valid = 1'b0;
                    m_out.sop   = 1'b0;
                    m_out.eop   = 1'b0;
`endif
                end
            end else if (b.sop) begin
                m_err++;
                if (b.eop) begin complete(fb); m_inpkt = 0; end
                else m_cur = 8;
            end else if (b.eop) begin
                complete(m_cur + fb);
                m_inpkt = 0;
            end else begin
                m_cur += 8;
            end
        end
        if (c) begin
            m_pkt = 0; m_bytes = 0; m_err = 0; m_stray = 0; m_last = 0; m_max = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".out"},    128'(out_a),   128'(m_out));
        check_val({tag, ".out_s"},  128'(out_b),   128'(m_out));
        check_val({tag, ".in_pkt"}, 128'(inpkt_a), 128'(m_inpkt));
        check_val({tag, ".in_pkt_s"}, 128'(inpkt_b), 128'(m_inpkt));
        check_val({tag, ".pkt"},    128'(pkt_a),   128'(sat(m_pkt, 32)));
        check_val({tag, ".bytes"},  128'(byte_a),  128'(sat(m_bytes, 32)));
        check_val({tag, ".soperr"}, 128'(err_a),   128'(sat(m_err, 32)));
        check_val({tag, ".stray"},  128'(stray_a), 128'(sat(m_stray, 32)));
        check_val({tag, ".last"},   128'(last_a),  128'(sat(m_last, 16)));
        check_val({tag, ".max"},    128'(max_a),   128'(sat(m_max, 16)));
        check_val({tag, ".pkt_s"},  128'(pkt_b),   128'(sat(m_pkt, 4)));
        check_val({tag, ".bytes_s"}, 128'(byte_b), 128'(sat(m_bytes, 4)));
        check_val({tag, ".soperr_s"}, 128'(err_b), 128'(sat(m_err, 4)));
        check_val({tag, ".stray_s"}, 128'(stray_b), 128'(sat(m_stray, 4)));
        check_val({tag, ".last_s"}, 128'(last_b),  128'(sat(m_last, 8)));
        check_val({tag, ".max_s"},  128'(max_b),   128'(sat(m_max, 8)));
    endtask

    task automatic step(input string tag, input avln_st b, input logic c);
        @(negedge clk);
        in_s = b;
        clr  = c;
        model_step(b, c);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        in_s  = '0;
        clr   = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_s  = '0;
        clr   = 1'b0;
        model_reset();
        do_reset("reset");

        // 4-beat packet, final beat empty=3 -> 29 bytes
        step("p4.sop", mk(1, 1, 0, 0), 1'b0);
        step("p4.b1",  mk(1, 0, 0, 5), 1'b0);
        step("p4.b2",  mk(1, 0, 0, 1), 1'b0);
        step("p4.eop", mk(1, 0, 1, 3), 1'b0);
        check_val("p4.len29", 128'(last_a), 128'(29));
        step("idle", mk(0, 1, 1, 2), 1'b0);
        step("single", mk(1, 1, 1, 0), 1'b0);
        check_val("single.len8", 128'(last_a), 128'(8));

        // Aborted packet followed by a two-beat one
        step("ab.sop",  mk(1, 1, 0, 0), 1'b0);
        step("ab.b1",   mk(1, 0, 0, 0), 1'b0);
        step("ab.sop2", mk(1, 1, 0, 0), 1'b0);
        step("ab.eop",  mk(1, 0, 1, 0), 1'b0);
        check_val("ab.len16", 128'(last_a), 128'(16));

        step("stray", mk(1, 0, 0, 0), 1'b0);

        for (int i = 0; i < 20; i++) step("sat.pkt", mk(1, 1, 1, i % 8), 1'b0);
        check_val("sat.pkt15", 128'(pkt_b), 128'(15));
        step("long.sop", mk(1, 1, 0, 0), 1'b0);
        for (int i = 0; i < 38; i++) step("long.mid", mk((i % 5) != 0, 0, 0, 0), 1'b0);
        for (int i = 0; i < 10; i++) step("long.mid2", mk(1, 0, 0, 0), 1'b0);
        step("long.eop", mk(1, 0, 1, 0), 1'b0);
        check_val("long.len255", 128'(last_b), 128'(255));

        // clr on eop, and a packet spanning a lone clr
        step("clr.sop", mk(1, 1, 0, 0), 1'b0);
        step("clr.eop", mk(1, 0, 1, 4), 1'b1);
        step("span.sop", mk(1, 1, 0, 0), 1'b0);
        step("span.clr", mk(0, 0, 0, 0), 1'b1);
        step("span.mid", mk(1, 0, 0, 0), 1'b0);
        step("span.eop", mk(1, 0, 1, 2), 1'b0);

        // Reset mid-packet, then a sop-less beat is stray
        step("rmp.sop", mk(1, 1, 0, 0), 1'b0);
        step("rmp.mid", mk(1, 0, 0, 0), 1'b0);
        do_reset("rmp.reset");
        step("rmp.stray", mk(1, 0, 1, 0), 1'b0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset("rnd.reset");
            end else begin
                step("rnd", mk($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                               $urandom_range(0, 7) == 0, $urandom_range(0, 7)),
                     $urandom_range(0, 99) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
